// File: rtl/rip_axi_master_arbiter.sv
// Round-robin arbiter sharing one rip_axi_master command port between NUM_REQ
// requesters; read and write channels are arbitrated independently.
module rip_axi_master_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_wvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_waddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]             req_wready,
  output logic [NUM_REQ-1:0]             req_wdone,
  input  logic [NUM_REQ-1:0]             req_rvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_raddr,
  output logic [NUM_REQ-1:0]             req_rready,
  output logic [NUM_REQ-1:0]             req_rdone,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  input  logic                           m_wready,
  input  logic                           m_wdone,
  input  logic                           m_rready,
  input  logic                           m_rdone,
  input  logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [ADDR_WIDTH-1:0]          m_waddr,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  output logic [STRB_W-1:0]              m_wstrb,
  output logic                           m_wvalid,
  output logic [ADDR_WIDTH-1:0]          m_raddr,
  output logic                           m_rvalid,
  output logic [IDX_W-1:0]               w_grant,
  output logic [IDX_W-1:0]               r_grant,
  output logic [1:0]                     busy
);

  // Handshake: a requester's request is accepted in the cycle req_*ready[i] is
  // high (only in IDLE); m_*valid holds until m_*ready, then req_*done[grant]
  // follows m_*done combinationally while the channel waits for completion.

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e            w_state, r_state;
  logic [IDX_W-1:0]  w_ptr, r_ptr;
  logic [IDX_W-1:0]  w_pick, r_pick;
  logic              w_found, r_found;

  // First set bit at or above ptr, wrapping; the rotate puts ptr at bit 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     pick;
    dbl  = {valid, valid} >> ptr;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
        pick = sum[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

  // Wraps modulo NUM_REQ so non power-of-two counts never reach unused indices.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  assign w_found   = |req_wvalid;
  assign r_found   = |req_rvalid;
  assign w_pick    = rr_pick(req_wvalid, w_ptr);
  assign r_pick    = rr_pick(req_rvalid, r_ptr);
  assign req_rdata = m_rdata;
  assign busy      = {r_state != ST_IDLE, w_state != ST_IDLE};

  always_comb begin
    req_wready = '0;
    req_wdone  = '0;
    req_rready = '0;
    req_rdone  = '0;
    if (rstn && w_state == ST_IDLE && w_found) req_wready[w_pick]  = 1'b1;
    if (w_state == ST_WAIT && m_wdone)         req_wdone[w_grant]  = 1'b1;
    if (rstn && r_state == ST_IDLE && r_found) req_rready[r_pick]  = 1'b1;
    if (r_state == ST_WAIT && m_rdone)         req_rdone[r_grant]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state  <= ST_IDLE;
      w_ptr    <= '0;
      w_grant  <= '0;
      m_wvalid <= 1'b0;
      m_waddr  <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
    end else begin
      case (w_state)
        ST_IDLE: if (w_found) begin
          m_waddr  <= req_waddr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata  <= req_wdata[w_pick*DATA_WIDTH +: DATA_WIDTH];
          m_wstrb  <= req_wstrb[w_pick*STRB_W +: STRB_W];
          w_grant  <= w_pick;
          m_wvalid <= 1'b1;
          w_state  <= ST_ISSUE;
        end
        ST_ISSUE: if (m_wready) begin
          m_wvalid <= 1'b0;
          w_state  <= ST_WAIT;
        end
        ST_WAIT: if (m_wdone) begin
          w_ptr   <= next_idx(w_grant);
          w_state <= ST_IDLE;
        end
        default: w_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      m_rvalid <= 1'b0;
      m_raddr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (r_found) begin
          m_raddr  <= req_raddr[r_pick*ADDR_WIDTH +: ADDR_WIDTH];
          r_grant  <= r_pick;
          m_rvalid <= 1'b1;
          r_state  <= ST_ISSUE;
        end
        ST_ISSUE: if (m_rready) begin
          m_rvalid <= 1'b0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: if (m_rdone) begin
          r_ptr   <= next_idx(r_grant);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_axi_master_arbiter.sv
// Directed and randomized bench for rip_axi_master_arbiter; a round-robin
// model keeps the expected grant sequence per channel.
module tb_rip_axi_master_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_wvalid, req_wready, req_wdone;
  logic [N*AW-1:0] req_waddr, req_raddr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    req_rvalid, req_rready, req_rdone;
  logic [DW-1:0]   req_rdata, m_rdata;
  logic            m_wready, m_wdone, m_rready, m_rdone;
  logic [AW-1:0]   m_waddr, m_raddr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wvalid, m_rvalid;
  logic            w_grant, r_grant;
  logic [1:0]      busy;

  int checks = 0;
  int errors = 0;
  int w_ptr  = 0;
  int r_ptr  = 0;

  rip_axi_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_wvalid(req_wvalid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wready(req_wready), .req_wdone(req_wdone),
    .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(req_rready),
    .req_rdone(req_rdone), .req_rdata(req_rdata),
    .m_wready(m_wready), .m_wdone(m_wdone), .m_rready(m_rready), .m_rdone(m_rdone),
    .m_rdata(m_rdata), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_raddr(m_raddr), .m_rvalid(m_rvalid),
    .w_grant(w_grant), .r_grant(r_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requester holding valid, scanning up from ptr with wrap.
  function automatic int rr_model(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic write_txn(input logic [N-1:0] mask);
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N];
    logic [SW-1:0] s[N];
    int g;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom; d[i] = $urandom; s[i] = SW'($urandom_range(0, 15));
      req_waddr[i*AW +: AW] = a[i];
      req_wdata[i*DW +: DW] = d[i];
      req_wstrb[i*SW +: SW] = s[i];
    end
    req_wvalid = mask;
    g = rr_model(w_ptr, mask);
    #1;
    chk("w_ready_grant", req_wready, 64'(1) << g);
    tick();
    chk("w_mvalid_up", m_wvalid, 1);
    chk("w_addr", m_waddr, a[g]);
    chk("w_data", m_wdata, d[g]);
    chk("w_strb", m_wstrb, s[g]);
    chk("w_grant", w_grant, g);
    chk("w_busy", busy[0], 1);
    chk("w_ready_busy", req_wready, 0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("w_mvalid_hold", m_wvalid, 1);
    end
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    chk("w_mvalid_drop", m_wvalid, 0);
    repeat ($urandom_range(0, 2)) tick();
    m_wdone = 1'b1;
    #1;
    chk("w_done", req_wdone, 64'(1) << g);
    tick();
    m_wdone    = 1'b0;
    req_wvalid = '0;
    w_ptr      = (g + 1) % N;
    chk("w_idle", busy[0], 0);
  endtask

  task automatic read_txn(input logic [N-1:0] mask);
    logic [AW-1:0] a[N];
    logic [DW-1:0] rd;
    int g;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      req_raddr[i*AW +: AW] = a[i];
    end
    req_rvalid = mask;
    g = rr_model(r_ptr, mask);
    #1;
    chk("r_ready_grant", req_rready, 64'(1) << g);
    tick();
    chk("r_mvalid_up", m_rvalid, 1);
    chk("r_addr", m_raddr, a[g]);
    chk("r_grant", r_grant, g);
    chk("r_busy", busy[1], 1);
    repeat ($urandom_range(0, 2)) tick();
    m_rready = 1'b1;
    tick();
    m_rready = 1'b0;
    chk("r_mvalid_drop", m_rvalid, 0);
    rd      = $urandom;
    m_rdata = rd;
    m_rdone = 1'b1;
    #1;
    chk("r_done", req_rdone, 64'(1) << g);
    chk("r_data", req_rdata, rd);
    tick();
    m_rdone    = 1'b0;
    req_rvalid = '0;
    r_ptr      = (g + 1) % N;
    chk("r_idle", busy[1], 0);
  endtask

  initial begin
    rstn = 1'b0;
    req_wvalid = 2'b11; req_rvalid = '0;
    req_waddr = '0; req_wdata = '0; req_wstrb = '0; req_raddr = '0;
    m_wready = 0; m_wdone = 0; m_rready = 0; m_rdone = 0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wready", req_wready, 0);
    chk("rst_mwvalid", m_wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wgrant", w_grant, 0);
    req_wvalid = '0;
    rstn = 1'b1;
    tick();

    // Single write from requester 0 with fixed payload.
    req_waddr[0 +: AW] = 32'h100; req_wdata[0 +: DW] = 32'hDEADBEEF; req_wstrb[0 +: SW] = 4'hF;
    req_wvalid = 2'b01;
    #1;
    chk("d_wready", req_wready, 2'b01);
    tick();
    req_wvalid = '0;
    chk("d_mwvalid", m_wvalid, 1);
    chk("d_maddr", m_waddr, 32'h100);
    chk("d_mdata", m_wdata, 32'hDEADBEEF);
    chk("d_mstrb", m_wstrb, 4'hF);
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    m_wdone  = 1'b1;
    #1;
    chk("d_wdone", req_wdone, 2'b01);
    tick();
    m_wdone = 1'b0;
    w_ptr   = 1;

    // Both requesters held: grants alternate, starting after last grant.
    repeat (4) write_txn(2'b11);

    // Read from requester 1 with known data.
    req_raddr[AW +: AW] = 32'h200;
    req_rvalid = 2'b10;
    #1;
    chk("d_rready", req_rready, 2'b10);
    tick();
    req_rvalid = '0;
    chk("d_mraddr", m_raddr, 32'h200);
    m_rready = 1'b1;
    tick();
    m_rready = 1'b0;
    m_rdata  = 32'h12345678;
    m_rdone  = 1'b1;
    #1;
    chk("d_rdone", req_rdone, 2'b10);
    chk("d_rdata", req_rdata, 32'h12345678);
    tick();
    m_rdone = 1'b0;
    r_ptr   = 0;

    // Read req0 and write req1 granted together.
    req_rvalid = 2'b01; req_wvalid = 2'b10;
    #1;
    chk("s_rready", req_rready, 2'b01);
    chk("s_wready", req_wready, 2'b10);
    tick();
    req_rvalid = '0; req_wvalid = '0;
    chk("s_busy", busy, 2'b11);
    m_wready = 1'b1; m_rready = 1'b1;
    tick();
    m_wready = 1'b0; m_rready = 1'b0;
    m_wdone = 1'b1; m_rdone = 1'b1;
    #1;
    chk("s_wdone", req_wdone, 2'b10);
    chk("s_rdone", req_rdone, 2'b01);
    tick();
    m_wdone = 1'b0; m_rdone = 1'b0;
    w_ptr = 0; r_ptr = 1;
    chk("s_busy_clr", busy, 0);

    // Stray completions while idle are ignored.
    m_wdone = 1'b1; m_rdone = 1'b1;
    #1;
    chk("stray_wdone", req_wdone, 0);
    chk("stray_rdone", req_rdone, 0);
    tick();
    m_wdone = 1'b0; m_rdone = 1'b0;
    chk("stray_busy", busy, 0);

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) write_txn(N'($urandom_range(1, 3)));
      else                           read_txn(N'($urandom_range(1, 3)));
    end

    // Reset while the write channel waits for completion.
    req_wvalid = 2'b10;
    tick();
    req_wvalid = '0;
    m_wready = 1'b1;
    tick();
    m_wready = 1'b0;
    chk("rw_busy_wait", busy[0], 1);
    rstn = 1'b0;
    #1;
    chk("rw_busy_rst", busy, 0);
    chk("rw_mwvalid", m_wvalid, 0);
    chk("rw_grant", w_grant, 0);
    tick();
    rstn  = 1'b1;
    w_ptr = 0; r_ptr = 0;
    m_wdone = 1'b1;
    #1;
    chk("rw_late_done", req_wdone, 0);
    tick();
    m_wdone = 1'b0;
    chk("rw_busy_after", busy, 0);
    write_txn(2'b11);
    read_txn(2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
